mux_4x1_32b: RTL and testbench

Four-way, 32-bit word selector used in the datapath wherever one of four operand/result buses must be steered onto a single bus under a 2-bit select (s1, s0). It provides a purely combinational output for same-cycle use and a registered copy of that output for pipeline-stage boundaries. The combinational path must remain usable with the clock and reset left unconnected.

---
 rtl/mux_4x1_32b_pkg.sv | 7 +
 rtl/mux_4x1_32b_mux2.sv | 24 ++
 rtl/mux_4x1_32b.sv | 62 ++++++
 tb/tb_mux_4x1_32b.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_4x1_32b_pkg.sv
// Shared datapath constants for the 4:1 word selector.
package mux_4x1_32b_pkg;

    // Native datapath word width.
    localparam int WORD_W = 32;

endpackage : mux_4x1_32b_pkg

// File: rtl/mux_4x1_32b_mux2.sv
// Two-way word selector: one stage of the 4:1 tree.
// An unknown select yields an all-X word instead of silently choosing i0.
module mux_2x1_32b
    import mux_4x1_32b_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] y
);

    // Select i0 for sel=0 and i1 for sel=1; anything else propagates X.
    always_comb begin
        // NOTE: y is assigned on every path (default arm included), so no latch is inferred.
        case (sel)
            1'b0:    y = i0;
            1'b1:    y = i1;
            default: y = 'x;
        endcase
    end

endmodule : mux_2x1_32b

// File: rtl/mux_4x1_32b.sv
// Four-way, 32-bit word selector with a combinational output Y and a
// registered copy Y_q. Y needs neither clock nor reset; only Y_q uses them.
module mux_4x1_32b
    import mux_4x1_32b_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Y,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] Y_q
);

    logic [WIDTH-1:0] w_ab;
    logic [WIDTH-1:0] w_cd;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;

    // Stage 1: s0 picks within each pair.
    mux_2x1_32b #(.WIDTH(WIDTH)) u_mux_ab (
        .sel (s0),
        .i0  (a),
        .i1  (b),
        .y   (w_ab)
    );

    mux_2x1_32b #(.WIDTH(WIDTH)) u_mux_cd (
        .sel (s0),
        .i0  (c),
        .i1  (d),
        .y   (w_cd)
    );

    // Stage 2: s1 picks between the two pair results.
    mux_2x1_32b #(.WIDTH(WIDTH)) u_mux_out (
        .sel (s1),
        .i0  (w_ab),
        .i1  (w_cd),
        .y   (w_y)
    );

    assign Y = w_y;

    // Pipeline copy of Y: loaded every rising edge, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_y;
        end
    end

    assign Y_q = r_y_q;

endmodule : mux_4x1_32b

// File: tb/tb_mux_4x1_32b.sv
// Directed self-checking bench for mux_4x1_32b.
module tb_mux_4x1_32b;

    logic        clk;
    logic        rst_n;
    logic        s1;
    logic        s0;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] Y;
    logic [31:0] Y_q;

    int n_cmp;
    int n_fail;

    mux_4x1_32b #(.WIDTH(32)) dut (
        .s1    (s1),
        .s0    (s0),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .Y     (Y),
        .clk   (clk),
        .rst_n (rst_n),
        .Y_q   (Y_q)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset holds Y_q at zero before any edge; Y is live regardless.
    task automatic test_reset();
        rst_n = 1'b0;
        {s1, s0} = 2'b00;
        a = 32'h1; b = 32'h2; c = 32'h3; d = 32'h4;
        #1;
        n_cmp++;
        if (Y_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_yq: got %h expected %h", Y_q, 32'h0);
        end
        n_cmp++;
        if (Y !== 32'h1) begin
            n_fail++;
            $display("FAIL reset_y_live: got %h expected %h", Y, 32'h1);
        end
    endtask

    // Combinational select, held in reset, 100 time units per step.
    task automatic test_comb_select();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h1; exp_tab[1] = 32'h2; exp_tab[2] = 32'h3; exp_tab[3] = 32'h4;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = k[1:0];
            #100;
            n_cmp++;
            if (Y !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL comb_sel%0d: got %h expected %h", k, Y, exp_tab[k]);
            end
        end
    endtask

    // With {s1,s0}=10, Y follows c only.
    task automatic test_comb_follow();
        {s1, s0} = 2'b10;
        c = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (Y !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL follow_c: got %h expected %h", Y, 32'hFFFF_FFFF);
        end
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; d = 32'h0F0F_0F0F;
        #1;
        n_cmp++;
        if (Y !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL ignore_abd: got %h expected %h", Y, 32'hFFFF_FFFF);
        end
        a = 32'h1; b = 32'h2; c = 32'h3; d = 32'h4;
    endtask

    // Async clear between edges, then first edge after release loads Y.
    task automatic test_async_reset();
        @(negedge clk);
        {s1, s0} = 2'b00;
        a = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (Y_q !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL preload: got %h expected %h", Y_q, 32'hDEAD_BEEF);
        end
        #1 rst_n = 1'b0;   // mid-high-phase, no edge nearby
        #1;
        n_cmp++;
        if (Y_q !== 32'h0) begin
            n_fail++;
            $display("FAIL async_clear: got %h expected %h", Y_q, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (Y_q !== 32'h0) begin
            n_fail++;
            $display("FAIL hold_after_release: got %h expected %h", Y_q, 32'h0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (Y_q !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL first_edge_load: got %h expected %h", Y_q, 32'hDEAD_BEEF);
        end
        a = 32'h1;
    endtask

    // One select step per cycle; Y_q must lag Y by exactly one edge.
    task automatic test_clocked_sweep();
        logic [31:0] exp_tab [4];
        logic [31:0] prev;
        exp_tab[0] = 32'h1; exp_tab[1] = 32'h2; exp_tab[2] = 32'h3; exp_tab[3] = 32'h4;
        @(negedge clk);
        {s1, s0} = 2'b11;
        @(posedge clk); #1;
        prev = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            {s1, s0} = k[1:0];
            #1;
            n_cmp++;
            if (Y_q !== prev) begin
                n_fail++;
                $display("FAIL sweep_lag%0d: got %h expected %h", k, Y_q, prev);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (Y_q !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL sweep_load%0d: got %h expected %h", k, Y_q, exp_tab[k]);
            end
            prev = exp_tab[k];
        end
    endtask

    // Select and data change together; the edge captures the settled Y.
    task automatic test_back_to_back();
        @(negedge clk);
        {s1, s0} = 2'b01;
        b = 32'hCAFE_F00D;
        @(posedge clk); #1;
        n_cmp++;
        if (Y_q !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL same_cycle: got %h expected %h", Y_q, 32'hCAFE_F00D);
        end
        b = 32'h2;
    endtask

    // Reset pulled low mid-sweep: Y_q clears at once, Y keeps its value.
    task automatic test_reset_mid_sweep();
        @(negedge clk);
        {s1, s0} = 2'b01;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (Y_q !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_clear: got %h expected %h", Y_q, 32'h0);
        end
        n_cmp++;
        if (Y !== 32'h2) begin
            n_fail++;
            $display("FAIL mid_y_kept: got %h expected %h", Y, 32'h2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Unknown select must not default to a (only observable in 4-state sims).
    task automatic test_x_select();
        s1 = 1'b0;
        s0 = 1'bx;
        #1;
        if ($isunknown(s0)) begin
            n_cmp++;
            if (!$isunknown(Y)) begin
                n_fail++;
                $display("FAIL x_select: got %h expected X", Y);
            end
        end
        s0 = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_comb_select();
        test_comb_follow();
        test_async_reset();
        test_clocked_sweep();
        test_back_to_back();
        test_reset_mid_sweep();
        test_x_select();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_4x1_32b
